// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester Y86 ALU sharing controller:
// widths, ifun codes, condition-code bit positions and FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_W    = 64;
  localparam int unsigned ALU_NREQ = 2;
  localparam int unsigned IFUN_W   = 4;
  localparam int unsigned CC_W     = 3;

  localparam logic [IFUN_W-1:0] ALU_ADD = 4'h0;
  localparam logic [IFUN_W-1:0] ALU_SUB = 4'h1;
  localparam logic [IFUN_W-1:0] ALU_AND = 4'h2;
  localparam logic [IFUN_W-1:0] ALU_XOR = 4'h3;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Codes above xor are reserved in this ALU.
  function automatic logic ifun_legal(input logic [IFUN_W-1:0] ifun);
    return ifun <= ALU_XOR;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/result bundle between the requesters/consumer (master) and the
// ALU sharing controller (slave).
interface alu_share_ctrl_if #(
  parameter int unsigned W    = alu_pkg::ALU_W,
  parameter int unsigned NREQ = alu_pkg::ALU_NREQ
);

  logic [NREQ-1:0]                  req_valid;
  logic [NREQ-1:0]                  req_ready;
  logic [NREQ*alu_pkg::IFUN_W-1:0]  req_ifun;
  logic [NREQ*W-1:0]                req_a;
  logic [NREQ*W-1:0]                req_b;
  logic                             res_valid;
  logic                             res_ready;
  logic                             res_id;
  logic [W-1:0]                     res_val;
  logic [alu_pkg::CC_W-1:0]         res_cc;
  logic                             res_err;

  modport master (
    output req_valid, req_ifun, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_val, res_cc, res_err
  );

  modport slave (
    input  req_valid, req_ifun, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_val, res_cc, res_err
  );

endinterface

// File: rtl/alu_share_ctrl_core.sv
// Combinational Y86 ALU: add/sub/and/xor in W+1 sign-extended bits with
// ZF/SF/OF generation; illegal ifun yields zero result, zero cc and err.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [IFUN_W-1:0] ifun,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic [W-1:0]      res,
  output logic [CC_W-1:0]   cc,
  output logic              err
);

  logic [W:0] ax;
  logic [W:0] bx;
  logic [W:0] sum;
  logic       sum_msb_unused;

  assign ax             = {a[W-1], a};
  assign bx             = {b[W-1], b};
  assign sum_msb_unused = sum[W];

  always_comb begin
    sum = '0;
    err = !ifun_legal(ifun);
    case (ifun)
      ALU_ADD: sum = ax + bx;
      ALU_SUB: sum = ax + ~bx + (W+1)'(1);
      ALU_AND: sum = ax & bx;
      ALU_XOR: sum = ax ^ bx;
      default: sum = '0;
    endcase
    res = sum[W-1:0];

    // Illegal ops must report cc=000 even though the zero result would set ZF.
    cc = '0;
    if (!err) begin
      cc[CC_ZF] = (res == '0);
      cc[CC_SF] = res[W-1];
      if (ifun == ALU_ADD) begin
        cc[CC_OF] = (a[W-1] == b[W-1]) & (res[W-1] != a[W-1]);
      end else if (ifun == ALU_SUB) begin
        cc[CC_OF] = (a[W-1] != b[W-1]) & (res[W-1] != a[W-1]);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter, EMPTY/FULL result FSM and registered result stage
// sharing one alu_core between two requesters.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W    = ALU_W,
  parameter int unsigned NREQ = ALU_NREQ
) (
  input  logic            clk,
  input  logic            reset,
  alu_share_ctrl_if.slave bus
);

  state_t            state_q;
  state_t            state_n;
  logic              last_grant_q;
  logic              can_issue_c;
  logic              sel_c;
  logic [NREQ-1:0]   grant_c;
  logic              granted_c;

  logic [IFUN_W-1:0] mux_ifun_c;
  logic [W-1:0]      mux_a_c;
  logic [W-1:0]      mux_b_c;
  logic [W-1:0]      core_res_c;
  logic [CC_W-1:0]   core_cc_c;
  logic              core_err_c;

  logic              res_id_q;
  logic [W-1:0]      res_val_q;
  logic [CC_W-1:0]   res_cc_q;
  logic              res_err_q;

  // Arbitration and next state; a tie goes to the requester not granted last.
  always_comb begin
    state_n     = state_q;
    grant_c     = '0;
    sel_c       = 1'b0;
    can_issue_c = (state_q == ST_EMPTY) | bus.res_ready;
    if (can_issue_c && !reset) begin
      if (bus.req_valid[0] && bus.req_valid[1]) begin
        sel_c = ~last_grant_q;
      end else begin
        sel_c = bus.req_valid[1];
      end
      grant_c[sel_c] = |bus.req_valid;
    end
    case (state_q)
      ST_EMPTY: if (|grant_c) state_n = ST_FULL;
      ST_FULL:  if (bus.res_ready && !(|grant_c)) state_n = ST_EMPTY;
      default:  state_n = ST_EMPTY;
    endcase
  end

  assign granted_c = |grant_c;

  assign mux_ifun_c = sel_c ? bus.req_ifun[IFUN_W +: IFUN_W] : bus.req_ifun[0 +: IFUN_W];
  assign mux_a_c    = sel_c ? bus.req_a[W +: W] : bus.req_a[0 +: W];
  assign mux_b_c    = sel_c ? bus.req_b[W +: W] : bus.req_b[0 +: W];

  alu_core #(.W(W)) u_core (
    .ifun (mux_ifun_c),
    .a    (mux_a_c),
    .b    (mux_b_c),
    .res  (core_res_c),
    .cc   (core_cc_c),
    .err  (core_err_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_n;
    end
  end

  // Result register only loads on a handshake, so it holds under back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      res_id_q     <= 1'b0;
      res_val_q    <= '0;
      res_cc_q     <= '0;
      res_err_q    <= 1'b0;
    end else if (granted_c) begin
      last_grant_q <= sel_c;
      res_id_q     <= sel_c;
      res_val_q    <= core_res_c;
      res_cc_q     <= core_cc_c;
      res_err_q    <= core_err_c;
    end
  end

  assign bus.req_ready = grant_c;
  assign bus.res_valid = (state_q == ST_FULL);
  assign bus.res_id    = res_id_q;
  assign bus.res_val   = res_val_q;
  assign bus.res_cc    = res_cc_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.W(64), .NREQ(2)) bus ();

  alu_share_ctrl #(.W(64), .NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model: one pending result slot plus the last winner.
  logic        m_valid;
  int          m_id;
  logic [63:0] m_val;
  logic [2:0]  m_cc;
  logic        m_err;
  int          m_last;
  logic [1:0]  rdy_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Overflow = exact signed result not representable in 64 bits.
  task automatic alu_ref(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [2:0] cc, output logic e);
    logic signed [63:0] sa, sb, sr;
    logic signed [65:0] ex;
    logic               of;
    sa = a; sb = b; ex = '0; of = 1'b0; e = 1'b0;
    case (f)
      4'd0: ex = sa + sb;
      4'd1: ex = sa - sb;
      4'd2: ex = 66'(a & b);
      4'd3: ex = 66'(a ^ b);
      default: e = 1'b1;
    endcase
    r  = ex[63:0];
    sr = r;
    if (f == 4'd0 || f == 4'd1) of = (ex != sr);
    cc = e ? 3'b000 : {r == 64'd0, r[63], of};
  endtask

  function automatic int pick(input logic [1:0] v, input logic rr);
    if (m_valid && !rr) return -1;
    if (v == 2'b11) return 1 - m_last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 0; m_val = '0; m_cc = '0; m_err = 1'b0; m_last = 1;
  endtask

  // One clock: drive at negedge, check ready, update model at posedge, check result.
  task automatic cycle(input logic [1:0] v,
                       input logic [3:0] f0, input logic [63:0] a0, input logic [63:0] b0,
                       input logic [3:0] f1, input logic [63:0] a1, input logic [63:0] b1,
                       input logic rr);
    int g;
    logic [63:0] a, b;
    logic [3:0]  f;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_ifun  = {f1, f0};
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.res_ready = rr;
    #1;
    g = pick(v, rr);
    rdy_seen = bus.req_ready;
    chk("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clk);
    if (g >= 0) begin
      f = (g == 0) ? f0 : f1;
      a = (g == 0) ? a0 : a1;
      b = (g == 0) ? b0 : b1;
      alu_ref(f, a, b, m_val, m_cc, m_err);
      m_valid = 1'b1;
      m_id    = g;
      m_last  = g;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    #1;
    chk("res_valid", 64'(bus.res_valid), 64'(m_valid));
    if (m_valid) begin
      chk("res_id",  64'(bus.res_id),  64'(m_id));
      chk("res_val", bus.res_val,      m_val);
      chk("res_cc",  64'(bus.res_cc),  64'(m_cc));
      chk("res_err", 64'(bus.res_err), 64'(m_err));
    end
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic logic [3:0] rand_ifun();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8) return 4'(r % 4);
    return 4'($urandom_range(4, 15));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_ifun  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_id",    64'(bus.res_id),    64'd0);
    chk("rst_res_val",   bus.res_val,        64'd0);
    chk("rst_res_cc",    64'(bus.res_cc),    64'd0);
    chk("rst_res_err",   64'(bus.res_err),   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    reset = 1'b0;

    // Single add
    cycle(2'b01, ALU_ADD, 64'd5, 64'd7, 4'h0, 64'd0, 64'd0, 1'b1);
    chk("add_rdy", 64'(rdy_seen), 64'd1);
    chk("add_val", bus.res_val, 64'd12);
    chk("add_cc",  64'(bus.res_cc), 64'd0);
    chk("add_id",  64'(bus.res_id), 64'd0);
    chk("add_err", 64'(bus.res_err), 64'd0);
    cycle(2'b00, 4'h0, 64'd0, 64'd0, 4'h0, 64'd0, 64'd0, 1'b1);

    // Subtract overflow and zero result from req1
    cycle(2'b10, 4'h0, 64'd0, 64'd0, ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    chk("subov_val", bus.res_val, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("subov_cc",  64'(bus.res_cc), 64'd1);
    chk("subov_id",  64'(bus.res_id), 64'd1);
    cycle(2'b10, 4'h0, 64'd0, 64'd0, ALU_SUB, 64'd3, 64'd3, 1'b1);
    chk("subz_val", bus.res_val, 64'd0);
    chk("subz_cc",  64'(bus.res_cc), 64'd4);
    cycle(2'b00, 4'h0, 64'd0, 64'd0, 4'h0, 64'd0, 64'd0, 1'b1);

    // Back-pressure: result held, no grants, then release grants same cycle
    cycle(2'b01, ALU_ADD, 64'd1, 64'd2, 4'h0, 64'd0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(2'b11, ALU_XOR, 64'hF0, 64'h0F, ALU_AND, 64'hFF, 64'h0F, 1'b0);
      chk("bp_rdy",   64'(rdy_seen), 64'd0);
      chk("bp_valid", 64'(bus.res_valid), 64'd1);
      chk("bp_val",   bus.res_val, 64'd3);
    end
    cycle(2'b11, ALU_XOR, 64'hF0, 64'h0F, ALU_AND, 64'hFF, 64'h0F, 1'b1);
    chk("bp_rel_rdy", 64'(rdy_seen), 64'd2);
    chk("bp_rel_val", bus.res_val, 64'h0F);
    cycle(2'b00, 4'h0, 64'd0, 64'd0, 4'h0, 64'd0, 64'd0, 1'b1);

    // Illegal ifun
    cycle(2'b01, 4'h7, 64'd9, 64'd9, 4'h0, 64'd0, 64'd0, 1'b1);
    chk("ill_rdy", 64'(rdy_seen), 64'd1);
    chk("ill_err", 64'(bus.res_err), 64'd1);
    chk("ill_val", bus.res_val, 64'd0);
    chk("ill_cc",  64'(bus.res_cc), 64'd0);

    // Async reset while FULL and stalled
    cycle(2'b01, ALU_ADD, 64'd4, 64'd4, 4'h0, 64'd0, 64'd0, 1'b1);
    cycle(2'b00, 4'h0, 64'd0, 64'd0, 4'h0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    bus.req_valid = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.res_valid), 64'd0);
    chk("arst_rdy",   64'(bus.req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    reset = 1'b0;

    // Contention: alternating grants starting with req0
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, ALU_ADD, 64'(i), 64'd100, ALU_SUB, 64'(i), 64'd100, 1'b1);
      chk("cont_rdy", 64'(rdy_seen), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("cont_id",  64'(bus.res_id), 64'(i % 2));
    end

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(2'($urandom_range(0, 3)), rand_ifun(), rand64(), rand64(),
            rand_ifun(), rand64(), rand64(), ($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbitration and sequencing controller that shares one 64-bit Y86 ALU (add/sub/and/xor) between two requesters, e.g. the execute stage and an address/compare helper.
- Accepts operand/function requests over valid/ready handshakes and grants one per cycle, round-robin.
- Drives the shared ALU core and returns a registered result with Y86 condition codes (ZF, SF, OF) and the ID of the requester that issued it.

Parameters:
- W, 64, operand/result width in bits.
- NREQ, 2, number of requesters (fixed at 2 for this revision; the pointer logic is written for 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; a handshake occurs when req_valid[i] & req_ready[i].
- req_ifun  in  NREQ*4  per-requester Y86 ifun: 0 add, 1 sub (A−B), 2 and, 3 xor; 4–15 illegal.
- req_a  in  NREQ*W  per-requester operand A.
- req_b  in  NREQ*W  per-requester operand B.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts the result this cycle.
- res_id  out  1  index of the requester that issued the result.
- res_val  out  W  ALU result.
- res_cc  out  3  {ZF, SF, OF}.
- res_err  out  1  issued ifun was illegal.

Behaviour:
- Reset (async, active-high) sets res_valid=0, res_id=0, res_val=0, res_cc=0, res_err=0, state=EMPTY, last_grant=1, so req0 wins the first tie.
- req_ready is 0 for all requesters while reset is high.
- State machine has two states:
  - EMPTY: output register free.
  - FULL: output register holds an unconsumed result.
- can_issue = (state==EMPTY) | (state==FULL & res_ready).
- Grant rule:
  - When can_issue, grant the single valid requester.
  - If both are valid, grant the requester != last_grant.
  - req_ready is combinational from req_valid, state and res_ready. It never depends on req_ifun, req_a or req_b.
  - At most one req_ready bit is high per cycle.
  - last_grant updates only on a handshake.
- Latency:
  - Operands accepted at edge N appear on res_* after edge N, i.e. one cycle, registered.
  - Throughput is one result per cycle when res_ready is held high.
- Transitions:
  - EMPTY → FULL on grant.
  - FULL → FULL on res_ready & grant: new result overwrites the old one in the same edge.
  - FULL → EMPTY on res_ready & no grant.
  - FULL holds on !res_ready.
- Stability: while res_valid & !res_ready, all res_* outputs hold stable.
- Arithmetic: the shared core computes in W+1 bits, sign-extended, and drops the top bit for res_val.
  - add: res = A+B.
  - sub: res = A+~B+1, i.e. A−B.
  - and / xor: bitwise.
- Condition codes:
  - ZF = (res==0).
  - SF = res[W−1].
  - add OF = (A[W−1]==B[W−1]) & (res[W−1]!=A[W−1]).
  - sub OF = (A[W−1]!=B[W−1]) & (res[W−1]!=A[W−1]).
  - and/xor OF = 0.
- Illegal ifun (4–15) is still a handshake. It produces res_val=0, res_cc=0, res_err=1.
- Reset mid-operation: a pending FULL result is discarded and any in-flight request is not acknowledged. Requesters re-present after reset.
- A requester that drops req_valid without a handshake has no effect. There is no internal request queue.

Decomposition:
- Shared package (alu_pkg) holds:
  - ifun constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3.
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
  - State encoding ST_EMPTY / ST_FULL.
- One combinational sub-module, alu_core (ifun, a, b → res, cc, err), instantiated once and fed by the granted requester's mux output.
- The controller holds the arbiter, FSM and output register.

Test Plan:
- Single request: req0 add A=5, B=7 with res_ready=1 → req_ready[0]=1 same cycle; next cycle res_val=12, cc=000, res_id=0, res_err=0.
- Sub overflow: req1 sub A=0x8000_0000_0000_0000, B=1 → res_val=0x7FFF_FFFF_FFFF_FFFF, cc=001 (OF only). Also sub A=3, B=3 → res_val=0, cc=100.
- Contention: both valid continuously, res_ready=1 → grants alternate 0,1,0,1 starting with req0 after reset; res_id follows one cycle later; one result per cycle.
- Back-pressure: res_ready=0 after the first result → res_* held stable, req_ready all 0, state FULL. Raise res_ready → pending result consumed and next request granted the same cycle.
- Illegal ifun: req0 ifun=4'h7 → handshake completes; next cycle res_err=1, res_val=0, cc=000.
- Async reset while FULL with res_ready=0 → res_valid drops immediately without a clock edge. After release, req0 wins the first tie.
